// File: rtl/alu_seq_pkg.sv
// Shared opcodes, sequencer state encoding and helpers for the ALU operation sequencer.
package alu_seq_pkg;

  localparam logic [3:0] ALU_NOP = 4'h0;
  localparam logic [3:0] ALU_ADD = 4'h1;
  localparam logic [3:0] ALU_SUB = 4'h2;
  localparam logic [3:0] ALU_AND = 4'h3;
  localparam logic [3:0] ALU_OR  = 4'h4;
  localparam logic [3:0] ALU_XOR = 4'h5;
  localparam logic [3:0] ALU_MLO = 4'h6;
  localparam logic [3:0] ALU_MHI = 4'h7;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_EVAL = 2'd1,
    SEQ_OUT  = 2'd2
  } seq_state_e;

  // A wide request only makes sense for the low half of a multiply.
  function automatic logic is_wide_req(input logic [3:0] mode, input logic wide);
    return wide & (mode == ALU_MLO);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Decoder/ALU-side bundle of the sequencer: request handshake, ALU control and flag outputs.
interface alu_seq_if;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_mode;
  logic       req_wide;
  logic       flag_clr;
  logic       alu_ee;
  logic       alu_eo;
  logic [3:0] alu_mode;
  logic       alu_zero;
  logic       alu_carry;
  logic       res_strobe;
  logic       res_hi;
  logic       flag_z;
  logic       flag_c;
  logic       busy;

  modport slave (
    input  req_valid, req_mode, req_wide, flag_clr, alu_zero, alu_carry,
    output req_ready, alu_ee, alu_eo, alu_mode, res_strobe, res_hi, flag_z, flag_c, busy
  );

  modport master (
    output req_valid, req_mode, req_wide, flag_clr, alu_zero, alu_carry,
    input  req_ready, alu_ee, alu_eo, alu_mode, res_strobe, res_hi, flag_z, flag_c, busy
  );
endinterface

// File: rtl/alu_seq.sv
// ALU operation sequencer: evaluate/output phasing, MLO->MHI split of wide multiplies,
// and the architectural Z/C flag register.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int EVAL_CYCLES = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);

  localparam logic [3:0] CNT_LOAD = 4'(EVAL_CYCLES - 1);

  seq_state_e r_state;
  seq_state_e w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic [3:0] r_mode;
  logic [3:0] w_mode_nxt;
  logic       r_wide;
  logic       w_wide_nxt;
  logic       r_hi_pass;
  logic       w_hi_pass_nxt;
  logic       r_alu_ee;
  logic       r_alu_eo;
  logic       r_res_strobe;
  logic       r_res_hi;
  logic       r_flag_z;
  logic       r_flag_c;

  // Next-state decode for the IDLE/EVAL/OUT sequence
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_mode_nxt    = r_mode;
    w_wide_nxt    = r_wide;
    w_hi_pass_nxt = r_hi_pass;
    case (r_state)
      SEQ_IDLE: begin
        if (bus.req_valid) begin
          w_state_nxt   = SEQ_EVAL;
          w_cnt_nxt     = CNT_LOAD;
          w_mode_nxt    = bus.req_mode;
          w_wide_nxt    = is_wide_req(bus.req_mode, bus.req_wide);
          w_hi_pass_nxt = 1'b0;
        end else begin
          w_state_nxt = SEQ_IDLE;
        end
      end
      SEQ_EVAL: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = SEQ_OUT;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      SEQ_OUT: begin
        // The high half of a wide multiply reuses the same operands without a new handshake.
        if (r_wide && (r_mode == ALU_MLO)) begin
          w_state_nxt   = SEQ_EVAL;
          w_cnt_nxt     = CNT_LOAD;
          w_mode_nxt    = ALU_MHI;
          w_wide_nxt    = 1'b0;
          w_hi_pass_nxt = 1'b1;
        end else begin
          w_state_nxt = SEQ_IDLE;
        end
      end
      default: begin
        w_state_nxt = SEQ_IDLE;
      end
    endcase
  end

  // State, counter, opcode and registered ALU/result controls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= SEQ_IDLE;
      r_cnt        <= 4'd0;
      r_mode       <= 4'h0;
      r_wide       <= 1'b0;
      r_hi_pass    <= 1'b0;
      r_alu_ee     <= 1'b0;
      r_alu_eo     <= 1'b0;
      r_res_strobe <= 1'b0;
      r_res_hi     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_mode       <= w_mode_nxt;
      r_wide       <= w_wide_nxt;
      r_hi_pass    <= w_hi_pass_nxt;
      r_alu_ee     <= (w_state_nxt != SEQ_IDLE);
      r_alu_eo     <= (w_state_nxt == SEQ_OUT);
      r_res_strobe <= (w_state_nxt == SEQ_OUT);
      r_res_hi     <= (w_state_nxt == SEQ_OUT) & w_hi_pass_nxt;
    end
  end

  // Flag register: an OUT-cycle capture wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag_z <= 1'b0;
      r_flag_c <= 1'b0;
    end else if (r_state == SEQ_OUT) begin
      r_flag_z <= bus.alu_zero;
      r_flag_c <= bus.alu_carry;
    end else if (bus.flag_clr) begin
      r_flag_z <= 1'b0;
      r_flag_c <= 1'b0;
    end else begin
      r_flag_z <= r_flag_z;
      r_flag_c <= r_flag_c;
    end
  end

  assign bus.req_ready  = (r_state == SEQ_IDLE);
  assign bus.busy       = (r_state != SEQ_IDLE);
  assign bus.alu_ee     = r_alu_ee;
  assign bus.alu_eo     = r_alu_eo;
  assign bus.alu_mode   = r_mode;
  assign bus.res_strobe = r_res_strobe;
  assign bus.res_hi     = r_res_hi;
  assign bus.flag_z     = r_flag_z;
  assign bus.flag_c     = r_flag_c;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: a behavioural 8-bit ALU plus a cycle-timeline model.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int E = 2;

  typedef struct {
    logic [3:0] mode;
    logic       wide;
    logic [7:0] a;
    logic [7:0] b;
    logic       clr_at_out;
  } op_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] cur_a;
  logic [7:0] cur_b;
  logic [9:0] w_alu;
  logic       exp_z;
  logic       exp_c;
  int         checks;
  int         errors;
  op_t        q[$];

  alu_seq_if bus_if ();

  alu_seq #(.EVAL_CYCLES(E)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: returns {zero, carry, result byte}
  function automatic logic [9:0] alu_fn(input logic [3:0] mode, input logic [7:0] a, input logic [7:0] b);
    logic [8:0]  s;
    logic [15:0] p;
    logic [7:0]  r;
    logic        c;
    s = 9'd0;
    p = 16'(a) * 16'(b);
    c = 1'b0;
    case (mode)
      ALU_ADD: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; end
      ALU_SUB: begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = s[8]; end
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_MLO: r = p[7:0];
      ALU_MHI: begin r = p[15:8]; c = (p[15:8] != 8'h00); end
      default: r = a;
    endcase
    return {(r == 8'h00), c, r};
  endfunction

  assign w_alu            = alu_fn(bus_if.alu_mode, cur_a, cur_b);
  assign bus_if.alu_zero  = w_alu[9];
  assign bus_if.alu_carry = w_alu[8];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs every queued op with req_valid held across the queue; called at a negedge while idle.
  task automatic run_queue();
    op_t        op;
    logic       wide_eff;
    logic [3:0] pass_mode;
    logic [9:0] pv;
    int         out1;
    int         out2;
    int         last;
    logic       strobe_exp;
    while (q.size() > 0) begin
      op = q.pop_front();
      bus_if.req_valid = 1'b1;
      bus_if.req_mode  = op.mode;
      bus_if.req_wide  = op.wide;
      cur_a = op.a;
      cur_b = op.b;
      chk1("ready_at_request", bus_if.req_ready, 1'b1);
      wide_eff = op.wide && (op.mode == ALU_MLO);
      out1 = E + 1;
      out2 = 2 * E + 2;
      last = wide_eff ? out2 : out1;
      for (int cyc = 1; cyc <= last + 1; cyc++) begin
        @(negedge clk);
        pass_mode  = (wide_eff && cyc > out1) ? ALU_MHI : op.mode;
        strobe_exp = (cyc == out1) || (wide_eff && cyc == out2);
        if (cyc <= last) begin
          chk1("ready", bus_if.req_ready, 1'b0);
          chk1("busy", bus_if.busy, 1'b1);
          chk1("alu_ee", bus_if.alu_ee, 1'b1);
          chk1("alu_eo", bus_if.alu_eo, strobe_exp);
          chk1("res_strobe", bus_if.res_strobe, strobe_exp);
          chk1("res_hi", bus_if.res_hi, wide_eff && cyc == out2);
          chk4("alu_mode", bus_if.alu_mode, pass_mode);
        end else begin
          chk1("ready_after", bus_if.req_ready, 1'b1);
          chk1("busy_after", bus_if.busy, 1'b0);
          chk1("alu_ee_after", bus_if.alu_ee, 1'b0);
          chk1("alu_eo_after", bus_if.alu_eo, 1'b0);
          chk1("strobe_after", bus_if.res_strobe, 1'b0);
          chk4("mode_held", bus_if.alu_mode, pass_mode);
        end
        chk1("flag_z", bus_if.flag_z, exp_z);
        chk1("flag_c", bus_if.flag_c, exp_c);
        bus_if.flag_clr = 1'b0;
        if (strobe_exp) begin
          pv = alu_fn(pass_mode, op.a, op.b);
          exp_z = pv[9];
          exp_c = pv[8];
          bus_if.flag_clr = op.clr_at_out;
        end
        if (cyc == 1) begin
          if (q.size() > 0) begin
            bus_if.req_mode = q[0].mode;
            bus_if.req_wide = q[0].wide;
          end else begin
            bus_if.req_valid = 1'b0;
          end
        end
      end
    end
  endtask

  function automatic op_t mk(input logic [3:0] m, input logic w, input logic [7:0] a,
                             input logic [7:0] b, input logic clr);
    op_t o;
    o.mode = m; o.wide = w; o.a = a; o.b = b; o.clr_at_out = clr;
    return o;
  endfunction

  initial begin
    logic [3:0] modes [6];
    modes = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR, ALU_MLO, ALU_MHI};
    checks = 0;
    errors = 0;
    exp_z = 1'b0;
    exp_c = 1'b0;
    cur_a = 8'h00;
    cur_b = 8'h00;
    rst_n = 1'b0;
    bus_if.req_valid = 1'b0;
    bus_if.req_mode  = 4'h0;
    bus_if.req_wide  = 1'b0;
    bus_if.flag_clr  = 1'b0;
    repeat (2) @(negedge clk);
    chk1("rst_ready", bus_if.req_ready, 1'b1);
    chk1("rst_busy", bus_if.busy, 1'b0);
    chk1("rst_ee", bus_if.alu_ee, 1'b0);
    chk1("rst_eo", bus_if.alu_eo, 1'b0);
    chk4("rst_mode", bus_if.alu_mode, 4'h0);
    chk1("rst_strobe", bus_if.res_strobe, 1'b0);
    chk1("rst_hi", bus_if.res_hi, 1'b0);
    chk1("rst_z", bus_if.flag_z, 1'b0);
    chk1("rst_c", bus_if.flag_c, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed: narrow add with carry/zero, wide multiply, ignored wide bit, clear priority.
    q.push_back(mk(ALU_ADD, 1'b0, 8'h80, 8'h80, 1'b0));
    run_queue();
    chk1("add_z", bus_if.flag_z, 1'b1);
    chk1("add_c", bus_if.flag_c, 1'b1);
    q.push_back(mk(ALU_MLO, 1'b1, 8'h10, 8'h10, 1'b0));
    run_queue();
    q.push_back(mk(ALU_XOR, 1'b1, 8'h5A, 8'h0F, 1'b0));
    run_queue();
    q.push_back(mk(ALU_ADD, 1'b0, 8'hF0, 8'h20, 1'b1));
    run_queue();
    chk1("clr_prio_c", bus_if.flag_c, 1'b1);

    bus_if.flag_clr = 1'b1;
    @(negedge clk);
    bus_if.flag_clr = 1'b0;
    exp_z = 1'b0;
    exp_c = 1'b0;
    chk1("clr_idle_z", bus_if.flag_z, 1'b0);
    chk1("clr_idle_c", bus_if.flag_c, 1'b0);

    // Back-to-back with req_valid held.
    q.push_back(mk(ALU_SUB, 1'b0, 8'h01, 8'h02, 1'b0));
    q.push_back(mk(ALU_MLO, 1'b1, 8'hFF, 8'hFF, 1'b0));
    q.push_back(mk(ALU_ADD, 1'b1, 8'h00, 8'h00, 1'b0));
    run_queue();

    // Reset mid-EVAL of an add, after flags have been set.
    q.push_back(mk(ALU_ADD, 1'b0, 8'h80, 8'h80, 1'b0));
    run_queue();
    bus_if.req_valid = 1'b1;
    bus_if.req_mode  = ALU_ADD;
    bus_if.req_wide  = 1'b0;
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    chk1("pre_rst_ee", bus_if.alu_ee, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("async_ee", bus_if.alu_ee, 1'b0);
    chk1("async_eo", bus_if.alu_eo, 1'b0);
    chk1("async_ready", bus_if.req_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    exp_z = 1'b0;
    exp_c = 1'b0;
    chk1("post_rst_ready", bus_if.req_ready, 1'b1);
    chk1("post_rst_z", bus_if.flag_z, 1'b0);
    chk1("post_rst_c", bus_if.flag_c, 1'b0);

    // Reset during OUT: alu_eo must drop without a clock edge.
    bus_if.req_valid = 1'b1;
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    repeat (E) @(negedge clk);
    chk1("pre_rst_eo", bus_if.alu_eo, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("async_eo_out", bus_if.alu_eo, 1'b0);
    chk1("async_strobe_out", bus_if.res_strobe, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("no_partial_strobe", bus_if.res_strobe, 1'b0);
      chk4("rst_mode_held", bus_if.alu_mode, 4'h0);
    end

    // Randomized groups of three back-to-back ops.
    for (int g = 0; g < 8; g++) begin
      for (int j = 0; j < 3; j++) begin
        q.push_back(mk(modes[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                       8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                       1'($urandom_range(0, 1))));
      end
      run_queue();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
